// File: rtl/frog_lane_tracker.sv
// Tracks the frog within one car lane: column movement, upward exit hand-off,
// sticky collision flag and a one-hot frog pixel row for the display overlay.
module frog_lane_tracker #(
  parameter int unsigned MAX_COL   = 15,
  parameter int unsigned START_COL = 8,
  localparam int unsigned COL_W    = $clog2(MAX_COL + 1),
  localparam int unsigned PIX_W    = MAX_COL + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter,
  input  logic [COL_W-1:0] in_col,
  input  logic             left,
  input  logic             right,
  input  logic             up,
  input  logic [PIX_W-1:0] car_pixels,
  output logic             hit,
  output logic [PIX_W-1:0] frog_pixels,
  output logic             exit_up,
  output logic [COL_W-1:0] out_col
);

  typedef enum logic [1:0] {
    EMPTY,
    OCCUPIED,
    HIT
  } state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic             in_range;

  // Only reachable as false when the row is narrower than the column field.
  assign in_range = (32'(in_col) <= MAX_COL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      col     <= COL_W'(START_COL);
      hit     <= 1'b0;
      exit_up <= 1'b0;
      out_col <= '0;
    end else begin
      exit_up <= 1'b0;
      case (state)
        EMPTY: begin
          if (enter) begin
            state <= OCCUPIED;
            col   <= in_range ? in_col : COL_W'(START_COL);
          end
        end
        OCCUPIED: begin
          // Collision beats every move, including the hop out of the row.
          if (car_pixels[col]) begin
            state <= HIT;
            hit   <= 1'b1;
          end else if (up) begin
            state   <= EMPTY;
            exit_up <= 1'b1;
            out_col <= col;
          end else if (left && !right) begin
            if (col != COL_W'(MAX_COL)) col <= col + COL_W'(1);
          end else if (right && !left) begin
            if (col != '0) col <= col - COL_W'(1);
          end
        end
        HIT: begin
          hit <= 1'b1;
        end
        default: begin
          state <= EMPTY;
          hit   <= 1'b0;
        end
      endcase
    end
  end

  // Decoded from registered state/col only; no input reaches this output.
  assign frog_pixels = (state == EMPTY) ? '0 : (PIX_W'(1) << col);

endmodule

// File: tb/tb_frog_lane_tracker.sv
// Directed bench for frog_lane_tracker: behavioural row model checked every
// cycle, plus hand-computed expectations at key points of the sequence.
module tb_frog_lane_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        enter;
  logic [3:0]  in_col;
  logic        left;
  logic        right;
  logic        up;
  logic [15:0] car_pixels;
  logic        hit;
  logic [15:0] frog_pixels;
  logic        exit_up;
  logic [3:0]  out_col;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model of the row: where the frog is, whether it was struck, last exit.
  bit m_in_row = 1'b0;
  bit m_hit    = 1'b0;
  bit m_exit   = 1'b0;
  int m_col    = 8;
  int m_out    = 0;

  frog_lane_tracker dut (
    .clk        (clk),
    .reset      (reset),
    .enter      (enter),
    .in_col     (in_col),
    .left       (left),
    .right      (right),
    .up         (up),
    .car_pixels (car_pixels),
    .hit        (hit),
    .frog_pixels(frog_pixels),
    .exit_up    (exit_up),
    .out_col    (out_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_in_row <= 1'b0;
      m_hit    <= 1'b0;
      m_exit   <= 1'b0;
      m_col    <= 8;
      m_out    <= 0;
    end else begin
      m_exit <= 1'b0;
      if (m_hit) begin
        // struck frog: frozen until reset
      end else if (!m_in_row) begin
        if (enter) begin
          m_in_row <= 1'b1;
          m_col    <= (int'(in_col) > 15) ? 8 : int'(in_col);
        end
      end else if (car_pixels[m_col] == 1'b1) begin
        m_hit <= 1'b1;
      end else if (up) begin
        m_in_row <= 1'b0;
        m_exit   <= 1'b1;
        m_out    <= m_col;
      end else if (left && !right) begin
        m_col <= (m_col + 1 > 15) ? 15 : m_col + 1;
      end else if (right && !left) begin
        m_col <= (m_col - 1 < 0) ? 0 : m_col - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("hit", 32'(hit), 32'(m_hit));
      chk("exit_up", 32'(exit_up), 32'(m_exit));
      chk("out_col", 32'(out_col), 32'(m_out));
      chk("frog_pixels", 32'(frog_pixels),
          (m_in_row || m_hit) ? (32'(1) << m_col) & 32'hFFFF : 32'h0);
    end
  end

  // One clock of stimulus; returns just after the edge that consumed it.
  task automatic cyc(input bit rs, input bit en, input logic [3:0] ic, input bit l,
                     input bit r, input bit u, input logic [15:0] car);
    @(negedge clk);
    #1;
    reset = rs; enter = en; in_col = ic; left = l; right = r; up = u; car_pixels = car;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [15:0] car);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, car);
  endtask

  initial begin
    reset = 1'b1; enter = 1'b0; in_col = '0; left = 1'b0; right = 1'b0; up = 1'b0;
    car_pixels = '0;
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk_en = 1'b1;
    chk("reset hit", 32'(hit), 32'h0);
    chk("reset frog_pixels", 32'(frog_pixels), 32'h0);
    chk("reset exit_up", 32'(exit_up), 32'h0);
    chk("reset out_col", 32'(out_col), 32'h0);

    // Moves in EMPTY are ignored.
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0);
    chk("empty ignores moves", 32'(frog_pixels), 32'h0);

    cyc(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("enter col5", 32'(frog_pixels), 32'h0020);
    chk("enter hit", 32'(hit), 32'h0);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("left to 6", 32'(frog_pixels), 32'h0040);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("left to 7", 32'(frog_pixels), 32'h0080);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("right to 6", 32'(frog_pixels), 32'h0040);
    cyc(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("enter while occupied", 32'(frog_pixels), 32'h0040);

    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("saturate at 15", 32'(frog_pixels), 32'h8000);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("saturate at 0", 32'(frog_pixels), 32'h0001);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("left+right no move", 32'(frog_pixels), 32'h0001);

    // Car shifts onto the frog at column 3.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0);
    idle(16'b0001100011000110);
    chk("car clear of col3", 32'(hit), 32'h0);
    chk("frog at col3", 32'(frog_pixels), 32'h0008);
    idle(16'b0011000110001100);
    chk("car onto col3", 32'(hit), 32'h1);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    idle(16'h0);
    chk("hit sticky", 32'(hit), 32'h1);
    chk("hit shows frog", 32'(frog_pixels), 32'h0008);

    // Clean exit at column 7 with left ignored.
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("reset clears hit", 32'(hit), 32'h0);
    cyc(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0);
    chk("exit pulse", 32'(exit_up), 32'h1);
    chk("exit col", 32'(out_col), 32'h7);
    chk("exit empties row", 32'(frog_pixels), 32'h0);
    idle(16'h0);
    chk("exit one cycle", 32'(exit_up), 32'h0);
    chk("out_col held", 32'(out_col), 32'h7);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0);
    chk("up in empty", 32'(exit_up), 32'h0);

    // Collision and up in the same cycle: collision wins.
    cyc(1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 16'h0010);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0010);
    chk("hit beats up", 32'(hit), 32'h1);
    chk("no exit on hit", 32'(exit_up), 32'h0);
    idle(16'h0);
    idle(16'h0);

    // Reset out of HIT, then step into a car: detected one cycle later.
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("recover hit", 32'(hit), 32'h0);
    chk("recover frog", 32'(frog_pixels), 32'h0200);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0400);
    chk("step into car pending", 32'(hit), 32'h0);
    idle(16'h0400);
    chk("step into car hit", 32'(hit), 32'h1);
    chk("frog at col10", 32'(frog_pixels), 32'h0400);
    idle(16'h0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
